// File: rtl/float_sort_pkg.sv
// -----------------------------------------------------------------------------
// float_sort_pkg
// Shared definitions for the float triple sort frontend:
//   FLEN_DEFAULT    - float width, same value as the shared project config (64)
//   TIMEOUT_DEFAULT - cycles after LAUNCH to wait for a sorter result
//   eng_state_t     - engine FSM state encoding
//   beat_idx_t      - index of a beat within a triple (also used as 0..3 count)
// -----------------------------------------------------------------------------
package float_sort_pkg;

    localparam int FLEN_DEFAULT    = 64;
    localparam int TIMEOUT_DEFAULT = 6;

    typedef enum logic [1:0] {
        ENG_IDLE   = 2'd0,
        ENG_LAUNCH = 2'd1,
        ENG_RUN    = 2'd2
    } eng_state_t;

    typedef logic [1:0] beat_idx_t;

    localparam beat_idx_t LAST_BEAT  = 2'd2;
    localparam beat_idx_t TRIPLE_CNT = 2'd3;

endpackage

// File: rtl/float_triple_collector.sv
// -----------------------------------------------------------------------------
// float_triple_collector
// Three-entry collection buffer with a 0..3 fill count. A beat is written at
// index count when in_valid & in_ready; clear empties the buffer (only issued
// while full, so it never collides with an accepted beat).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid/in_ready/in_data - upstream beat handshake
//   clear           - drop count to 0 (triple handed to the engine)
//   count           - number of beats held
//   triple          - packed buffer, element i at [i*FLEN +: FLEN]
// -----------------------------------------------------------------------------
module float_triple_collector
    import float_sort_pkg::*;
#(
    parameter int FLEN = FLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLEN-1:0]   in_data,
    input  logic              clear,
    output beat_idx_t         count,
    output logic [3*FLEN-1:0] triple
);

    logic [FLEN-1:0] slot [3];
    logic            take;

    assign in_ready = (count != TRIPLE_CNT);
    assign take     = in_valid & in_ready;
    assign triple   = {slot[2], slot[1], slot[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < 3; i++) begin
                slot[i] <= '0;
            end
        end else if (clear) begin
            count <= '0;
        end else if (take) begin
            slot[count] <= in_data;
            count       <= count + 2'd1;
        end
    end

endmodule

// File: rtl/float_stream_sort_frontend.sv
// -----------------------------------------------------------------------------
// float_stream_sort_frontend
// Groups an incoming float stream into triples, launches each triple to an
// external 3-element sorter, and replays the sorted result smallest first.
// A triple that the sorter flags, or that gets no answer within TIMEOUT
// cycles of LAUNCH, is replayed as three zero beats with out_err set.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   in_valid/in_ready/in_data      - upstream float stream
//   sort_valid_in, sort_unsorted   - launch to sorter (element 0 = first beat)
//   sort_valid_out, sort_sorted,
//   sort_err, sort_busy            - sorter result (busy is monitor only)
//   out_valid/out_ready/out_data,
//   out_last, out_err              - downstream sorted stream
//
// state  | meaning
// IDLE   | waiting for a full triple and an empty output buffer
// LAUNCH | one-cycle launch pulse; result may already be captured here
// RUN    | waiting for sorter result or timeout
// -----------------------------------------------------------------------------
module float_stream_sort_frontend
    import float_sort_pkg::*;
#(
    parameter int FLEN    = FLEN_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLEN-1:0]   in_data,
    output logic              sort_valid_in,
    output logic [3*FLEN-1:0] sort_unsorted,
    input  logic              sort_valid_out,
    input  logic [3*FLEN-1:0] sort_sorted,
    input  logic              sort_err,
    input  logic              sort_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLEN-1:0]   out_data,
    output logic              out_last,
    output logic              out_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    eng_state_t        state, state_nx;
    beat_idx_t         count;
    logic [3*FLEN-1:0] coll_triple;
    logic [3*FLEN-1:0] hold;
    logic [TW-1:0]     timer;
    logic              launch, capture, cap_err;

    logic [FLEN-1:0]   ob_data [3];
    logic              ob_full, ob_err;
    beat_idx_t         ob_idx;

    logic              sort_busy_unused;
    assign sort_busy_unused = sort_busy;

    float_triple_collector #(.FLEN(FLEN)) u_collector (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .clear    (launch),
        .count    (count),
        .triple   (coll_triple)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ENG_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Timer is a down-counter loaded at the launch decision; it reads TIMEOUT
    // in the LAUNCH cycle and reaches zero on the TIMEOUT-th cycle after it.
    always_comb begin
        state_nx      = state;
        launch        = 1'b0;
        capture       = 1'b0;
        cap_err       = 1'b0;
        sort_valid_in = 1'b0;
        case (state)
            ENG_IDLE: begin
                // sort_valid_out is deliberately ignored here: the sorter can
                // raise it off a stale hold value.
                if (count == TRIPLE_CNT && !ob_full) begin
                    launch   = 1'b1;
                    state_nx = ENG_LAUNCH;
                end
            end
            ENG_LAUNCH, ENG_RUN: begin
                sort_valid_in = (state == ENG_LAUNCH);
                if (sort_valid_out) begin
                    capture  = 1'b1;
                    cap_err  = sort_err;
                    state_nx = ENG_IDLE;
                end else if (timer == '0) begin
                    capture  = 1'b1;
                    cap_err  = 1'b1;
                    state_nx = ENG_IDLE;
                end else begin
                    state_nx = ENG_RUN;
                end
            end
            default: begin
                state_nx = ENG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
            hold  <= '0;
        end else if (launch) begin
            timer <= TW'(TIMEOUT);
            hold  <= coll_triple;
        end else if (state != ENG_IDLE && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign sort_unsorted = hold;

    // Capture only happens after a launch, and launch requires an empty
    // output buffer, so capture never overwrites an undrained triple.
    always_ff @(posedge clk) begin
        if (rst) begin
            ob_full <= 1'b0;
            ob_err  <= 1'b0;
            ob_idx  <= '0;
            for (int i = 0; i < 3; i++) begin
                ob_data[i] <= '0;
            end
        end else if (capture) begin
            ob_full <= 1'b1;
            ob_err  <= cap_err;
            ob_idx  <= '0;
            for (int i = 0; i < 3; i++) begin
                ob_data[i] <= cap_err ? '0 : sort_sorted[i*FLEN +: FLEN];
            end
        end else if (ob_full && out_ready) begin
            if (ob_idx == LAST_BEAT) begin
                ob_full <= 1'b0;
                ob_idx  <= '0;
            end else begin
                ob_idx  <= ob_idx + 2'd1;
            end
        end
    end

    assign out_valid = ob_full;
    assign out_data  = ob_data[ob_idx];
    assign out_last  = ob_full && (ob_idx == LAST_BEAT);
    assign out_err   = ob_full && ob_err;

endmodule

// File: tb/tb_float_stream_sort_frontend.sv
`timescale 1ns/1ps
module tb_float_stream_sort_frontend;

    localparam int FLEN    = 64;
    localparam int TIMEOUT = 6;

    localparam logic [FLEN-1:0] F_3_0 = 64'h4008000000000000;
    localparam logic [FLEN-1:0] F_1_0 = 64'h3FF0000000000000;
    localparam logic [FLEN-1:0] F_2_0 = 64'h4000000000000000;

    typedef enum int {SM_NORMAL, SM_ERR_NOW, SM_SILENT} smode_t;

    typedef struct packed {
        logic [FLEN-1:0] d;
        logic            last;
        logic            err;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [FLEN-1:0]   in_data = '0;
    logic              sort_valid_in;
    logic [3*FLEN-1:0] sort_unsorted;
    logic              sort_valid_out;
    logic [3*FLEN-1:0] sort_sorted;
    logic              sort_err;
    logic              sort_busy;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [FLEN-1:0]   out_data;
    logic              out_last;
    logic              out_err;

    float_stream_sort_frontend #(.FLEN(FLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .sort_valid_in  (sort_valid_in),
        .sort_unsorted  (sort_unsorted),
        .sort_valid_out (sort_valid_out),
        .sort_sorted    (sort_sorted),
        .sort_err       (sort_err),
        .sort_busy      (sort_busy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_err        (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [3*FLEN-1:0] got,
                             input logic [3*FLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3*FLEN-1:0] sort3(input logic [3*FLEN-1:0] t);
        logic [FLEN-1:0] v [3];
        logic [FLEN-1:0] tmp;
        for (int i = 0; i < 3; i++) v[i] = t[i*FLEN +: FLEN];
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 2 - p; i++)
                if ($bitstoreal(v[i]) > $bitstoreal(v[i+1])) begin
                    tmp = v[i]; v[i] = v[i+1]; v[i+1] = tmp;
                end
        return {v[2], v[1], v[0]};
    endfunction

    function automatic logic [FLEN-1:0] rnd_float();
        real r;
        r = ($itor($urandom_range(0, 4000)) - 2000.0) / 16.0;
        return $realtobits(r);
    endfunction

    // ---------------- behavioural sorter ----------------
    smode_t            smode = SM_NORMAL;
    logic              force_vo = 1'b0;
    int                lat_lo = 3, lat_hi = 3;
    logic              svi_s = 1'b0, rst_s = 1'b1;
    logic [3*FLEN-1:0] uns_s = '0;
    logic              resp_pend = 1'b0;
    int                resp_cnt = 0;
    logic [3*FLEN-1:0] resp_data = '0;

    always @(negedge clk) begin
        svi_s = sort_valid_in;
        uns_s = sort_unsorted;
        rst_s = rst;
    end

    always @(posedge clk) begin
        if (rst_s) begin
            resp_pend <= 1'b0;
            resp_cnt  <= 0;
        end else if (svi_s && smode == SM_NORMAL) begin
            resp_pend <= 1'b1;
            resp_cnt  <= $urandom_range(lat_lo, lat_hi);
            resp_data <= sort3(uns_s);
        end else if (resp_pend) begin
            if (resp_cnt == 1) resp_pend <= 1'b0;
            else               resp_cnt  <= resp_cnt - 1;
        end
    end

    assign sort_valid_out = force_vo |
        ((smode == SM_ERR_NOW) ? sort_valid_in : (resp_pend && resp_cnt == 1));
    assign sort_err    = (smode == SM_ERR_NOW) && sort_valid_in;
    assign sort_sorted = resp_data;
    assign sort_busy   = resp_pend;

    // ---------------- reference model + monitors ----------------
    logic [FLEN-1:0]   in_q[$];
    logic [3*FLEN-1:0] launch_q[$];
    beat_t             exp_q[$];
    logic              exp_fail_mode = 1'b0;

    int   launch_cyc = -1, first_acc_cyc = -1, ov_rise_cyc = -1, last_hs_cyc = -1;
    int   n_launch = 0, ov_seen = 0;
    logic prev_svi = 1'b0, prev_ov = 1'b0, hold_prev = 1'b0;
    logic [FLEN-1:0] hp_data = '0;
    logic hp_last = 1'b0, hp_err = 1'b0;

    always @(negedge clk) begin
        logic [3*FLEN-1:0] t, s;
        beat_t e;
        if (rst) begin
            prev_svi  = 1'b0;
            prev_ov   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (in_q.size() == 0) first_acc_cyc = cyc;
                in_q.push_back(in_data);
                if (in_q.size() == 3) begin
                    t = {in_q[2], in_q[1], in_q[0]};
                    launch_q.push_back(t);
                    s = exp_fail_mode ? '0 : sort3(t);
                    for (int i = 0; i < 3; i++)
                        exp_q.push_back('{d: s[i*FLEN +: FLEN], last: (i == 2), err: exp_fail_mode});
                    in_q.delete();
                end
            end
            if (sort_valid_in) begin
                check_val("launch_one_cycle", prev_svi, 0);
                n_launch++;
                launch_cyc = cyc;
                if (launch_q.size() == 0) check_val("launch_unexpected", sort_valid_in, 0);
                else check_val("sort_unsorted", sort_unsorted, launch_q.pop_front());
            end
            prev_svi = sort_valid_in;
            if (hold_prev) begin
                check_val("stall_valid", out_valid, 1);
                check_val("stall_data", out_data, hp_data);
                check_val("stall_last", out_last, hp_last);
                check_val("stall_err", out_err, hp_err);
            end
            if (out_valid && !prev_ov) ov_rise_cyc = cyc;
            if (out_valid) ov_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_val("out_unexpected", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    check_val("out_data", out_data, e.d);
                    check_val("out_last", out_last, e.last);
                    check_val("out_err", out_err, e.err);
                end
                if (out_last) last_hs_cyc = cyc;
            end
            hold_prev = out_valid && !out_ready;
            hp_data   = out_data;
            hp_last   = out_last;
            hp_err    = out_err;
            prev_ov   = out_valid;
        end
    end

    // ---------------- downstream ready driver ----------------
    logic rand_ready = 1'b0;
    logic ready_force = 1'b1;
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // ---------------- stimulus tasks ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        step(2);
        rst = 1'b0;
        in_q.delete();
        launch_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_state();
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_sort_valid_in", sort_valid_in, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_out_err", out_err, 0);
        check_val("rst_sort_unsorted", sort_unsorted, 0);
        check_val("rst_out_data", out_data, 0);
    endtask

    task automatic send_beat(input logic [FLEN-1:0] d);
        int  guard = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
            guard++;
            if (!done && guard > 200) begin
                check_val("send_timeout", in_ready, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || launch_q.size() != 0 || out_valid) && guard < 300) begin
            step(1);
            guard++;
        end
        check_val("drain_left", exp_q.size(), 0);
        step(2);
    endtask

    task automatic wait_ov_rise();
        int guard = 0;
        ov_rise_cyc = -1;
        while (ov_rise_cyc < 0 && guard < 100) begin step(1); guard++; end
    endtask

    task automatic lat_test();
        smode = SM_NORMAL; lat_lo = 3; lat_hi = 3; ready_force = 1'b1;
        launch_cyc = -1;
        ov_rise_cyc = -1;
        send_beat(F_3_0);
        send_beat(F_1_0);
        send_beat(F_2_0);
        wait_ov_rise();
        check_val("latency_launch", launch_cyc - first_acc_cyc, 4);
        check_val("latency_out_valid", ov_rise_cyc - first_acc_cyc, 8);
        wait_drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0, ov0, guard, t0;
        do_reset();
        chk_reset_state();

        // basic latency and known-value sort
        lat_test();

        // sorter flags error in the LAUNCH cycle
        smode = SM_ERR_NOW; exp_fail_mode = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(rnd_float());
        wait_drain();
        smode = SM_NORMAL; exp_fail_mode = 1'b0;

        // sorter never answers -> timeout, then a normal triple
        smode = SM_SILENT; exp_fail_mode = 1'b1;
        launch_cyc = -1;
        for (int i = 0; i < 3; i++) send_beat(rnd_float());
        wait_ov_rise();
        check_val("timeout_capture", ov_rise_cyc - launch_cyc, TIMEOUT + 1);
        wait_drain();
        smode = SM_NORMAL; exp_fail_mode = 1'b0; lat_lo = 1; lat_hi = TIMEOUT;
        for (int i = 0; i < 3; i++) send_beat(rnd_float());
        wait_drain();

        // downstream stalled for 20 cycles with six beats offered
        lat_lo = 2; lat_hi = 4;
        ready_force = 1'b0;
        step(1);
        t0 = cyc;
        n0 = n_launch;
        for (int i = 0; i < 6; i++) send_beat(rnd_float());
        while (cyc - t0 < 20) step(1);
        check_val("stall_in_ready_low", in_ready, 0);
        check_val("stall_one_launch", n_launch - n0, 1);
        check_val("stall_out_valid", out_valid, 1);
        last_hs_cyc = -1;
        ready_force = 1'b1;
        guard = 0;
        while (n_launch - n0 < 2 && guard < 50) begin step(1); guard++; end
        check_val("relaunch_after_drain", launch_cyc - last_hs_cyc, 2);
        wait_drain();

        // reset while in RUN
        lat_lo = 3; lat_hi = 3;
        n0 = n_launch;
        for (int i = 0; i < 3; i++) send_beat(rnd_float());
        guard = 0;
        while (n_launch == n0 && guard < 20) begin step(1); guard++; end
        do_reset();
        chk_reset_state();
        ov0 = ov_seen;
        step(15);
        check_val("rst_run_no_output", ov_seen - ov0, 0);
        lat_test();

        // reset with two beats collected
        send_beat(rnd_float());
        send_beat(rnd_float());
        do_reset();
        ov0 = ov_seen;
        n0 = n_launch;
        step(10);
        check_val("rst_cnt2_no_output", ov_seen - ov0, 0);
        check_val("rst_cnt2_no_launch", n_launch - n0, 0);
        lat_test();

        // spurious sorter valid while IDLE with a partial triple
        send_beat(rnd_float());
        ov0 = ov_seen;
        force_vo = 1'b1;
        step(6);
        force_vo = 1'b0;
        check_val("idle_vo_ignored", ov_seen - ov0, 0);
        send_beat(rnd_float());
        send_beat(rnd_float());
        wait_drain();

        // randomized streaming
        lat_lo = 1; lat_hi = TIMEOUT;
        rand_ready = 1'b1;
        for (int i = 0; i < 90; i++) begin
            step($urandom_range(0, 2));
            send_beat(rnd_float());
        end
        wait_drain();
        rand_ready = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/float_stream_sort_frontend.md
FLOAT_STREAM_SORT_FRONTEND -- requirements
Module: float_stream_sort_frontend

Interface
REQ-001 SHALL have parameter FLEN, default from config-shared.vh (64), meaning float width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 6, meaning the maximum number of cycles after launch to wait for the sorter result.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream float beat valid.
REQ-006 SHALL have port in_ready  output  1  frontend accepts a beat.
REQ-007 SHALL have port in_data  input  FLEN  upstream float.
REQ-008 SHALL have port sort_valid_in  output  1  launch pulse to sorter.
REQ-009 SHALL have port sort_unsorted  output  3xFLEN  triple to sorter, element 0 = first beat received.
REQ-010 SHALL have port sort_valid_out  input  1  sorter result valid.
REQ-011 SHALL have port sort_sorted  input  3xFLEN  sorter result, ascending.
REQ-012 SHALL have port sort_err  input  1  sorter comparison error.
REQ-013 SHALL have port sort_busy  input  1  sorter busy (monitor only, not used for control).
REQ-014 SHALL have port out_valid  output  1  downstream beat valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts a beat.
REQ-016 SHALL have port out_data  output  FLEN  sorted float, smallest first.
REQ-017 SHALL have port out_last  output  1  third beat of a triple.
REQ-018 SHALL have port out_err  output  1  triple errored or timed out.

Function
REQ-019 SHALL hold a 3-entry collection buffer with count 0..3; in_ready = (count < 3); a beat transfers when in_valid & in_ready and is written at index count.
REQ-020 SHALL run an engine FSM with states IDLE, LAUNCH, RUN.
REQ-021 IDLE: when count == 3 and the output buffer is empty, SHALL copy the collection buffer into a hold register, clear count to 0 and go to LAUNCH, all in one cycle.
REQ-022 SHALL drive sort_unsorted from the hold register only, stable from LAUNCH until return to IDLE.
REQ-023 SHALL assert sort_valid_in only in LAUNCH, for exactly one cycle per triple.
REQ-024 LAUNCH or RUN: sort_valid_out = 1 SHALL capture the result into the output buffer and return to IDLE; otherwise LAUNCH SHALL go to RUN.
REQ-025 On capture, sort_err = 1 SHALL store data 0 and set the triple's err flag; otherwise it SHALL store sort_sorted with err = 0.
REQ-026 SHALL count cycles since LAUNCH; if no sort_valid_out arrives by the TIMEOUT-th cycle after LAUNCH, it SHALL capture data 0 with err = 1 and return to IDLE.
REQ-027 SHALL ignore sort_valid_out in IDLE, since a stale-hold comparison error can raise it.
REQ-028 The output buffer SHALL present beats 0, 1, 2 in order; out_last = 1 on beat 2; out_err = triple flag on all three beats; out_valid, out_data, out_err and out_last SHALL stay stable while out_valid & !out_ready.
REQ-029 The output buffer SHALL become empty on the handshake of beat 2, and IDLE SHALL see it empty on the next cycle.
REQ-030 Collection SHALL continue during LAUNCH, RUN and emission, so one triple is collected while the previous one sorts or drains.
REQ-031 Latency: beats accepted on cycles 0, 1, 2 with the frontend empty SHALL give IDLE launch decision at 3, LAUNCH at 4, sorter result at 7, first out_valid at 8.

Reset
REQ-032 On rst SHALL set the engine to IDLE, count = 0, output buffer empty, timer = 0.
REQ-033 Reset values: in_ready = 1 and sort_valid_in, out_valid, out_last and out_err = 0; sort_unsorted, out_data and hold SHALL be 0.
REQ-034 Reset mid-operation SHALL discard every partial and in-flight triple without emitting it.

Structure
REQ-035 A shared package float_sort_pkg SHALL hold the engine state enum, the TIMEOUT default and the beat-index type; FLEN SHALL come from config-shared.vh.
REQ-036 The block SHALL NOT instantiate the sorter; it connects at the top level.
REQ-037 The only permitted sub-module is float_triple_collector (collection buffer plus count).

Verification
REQ-038 Stream 3.0, 1.0, 2.0 (0x4008..., 0x3FF0..., 0x4000...) with a behavioural sorter -> out 1.0, 2.0, 3.0; out_last on the 3.0 beat; first out_valid on cycle 8.
REQ-039 Sorter model asserts sort_err with sort_valid_out in the LAUNCH cycle -> three beats of data 0, out_err = 1, out_last on the third.
REQ-040 out_ready = 0 for 20 cycles and six input beats -> second triple collected, in_ready low after beat 6, sort_valid_in not re-pulsed until the beat-2 handshake.
REQ-041 Sorter model never asserts valid -> out_err triple captured exactly TIMEOUT cycles after LAUNCH; the next triple then sorts normally.
REQ-042 rst pulse in RUN, and separately with count = 2 -> no out_valid; a fresh triple then gives the REQ-031 latency.
REQ-043 sort_valid_out forced high in IDLE with count < 3 -> no capture, out_valid stays 0.
